// File: rtl/instr_pointer_stack.sv
// Fetch-stage instruction pointer with relative/absolute jumps, call/return and a
// bounded return-address stack that reports overflow/underflow as a sticky fault.
module instr_pointer_stack #(
  parameter int unsigned             WORD_WIDTH  = 16,
  parameter int unsigned             STACK_DEPTH = 8,
  parameter logic [WORD_WIDTH-1:0]   RESET_ADDR  = '0,
  parameter int unsigned             STEP        = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               en,
  input  logic [2:0]                         op,
  input  logic [WORD_WIDTH-1:0]              operand,
  output logic [WORD_WIDTH-1:0]              out,
  output logic [WORD_WIDTH-1:0]              top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty,
  output logic                               fault,
  output logic [1:0]                         fault_code
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [WORD_WIDTH-1:0] STEP_W    = WORD_WIDTH'(STEP);
  localparam logic [DW-1:0]         DEPTH_MAX = DW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD     = 3'd0,
    OP_STEP     = 3'd1,
    OP_REL      = 3'd2,
    OP_ABS      = 3'd3,
    OP_CALL_REL = 3'd4,
    OP_CALL_ABS = 3'd5,
    OP_RET      = 3'd6,
    OP_CLR      = 3'd7
  } op_e;

  logic [WORD_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [WORD_WIDTH-1:0] out_nxt;
  logic [WORD_WIDTH-1:0] ret_addr;
  logic [IW-1:0]         push_idx;
  logic [IW-1:0]         top_idx;
  logic                  is_call;
  logic                  is_ret;
  logic                  do_push;
  logic                  do_pop;
  logic                  overflow;
  logic                  underflow;
  op_e                   op_c;

  assign op_c     = op_e'(op);
  assign full     = (depth == DEPTH_MAX);
  assign empty    = (depth == '0);
  assign push_idx = depth[IW-1:0];
  assign top_idx  = IW'(depth - DW'(1));
  // Stale entries above depth are masked so an empty stack always reads zero.
  assign top      = empty ? '0 : stack_mem[top_idx];

  always_comb begin
    ret_addr  = out + STEP_W;
    is_call   = (op_c == OP_CALL_REL) || (op_c == OP_CALL_ABS);
    is_ret    = (op_c == OP_RET);
    do_push   = en && is_call && !full;
    do_pop    = en && is_ret && !empty;
    overflow  = en && is_call && full;
    underflow = en && is_ret && empty;
    out_nxt   = out;
    if (en) begin
      unique case (op_c)
        OP_STEP:     out_nxt = out + STEP_W;
        OP_REL:      out_nxt = out + operand;
        OP_ABS:      out_nxt = operand;
        OP_CALL_REL: if (!full) out_nxt = out + operand;
        OP_CALL_ABS: if (!full) out_nxt = operand;
        OP_RET:      if (!empty) out_nxt = top;
        default:     out_nxt = out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out        <= RESET_ADDR;
      depth      <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      out <= out_nxt;
      if (do_push)
        depth <= depth + DW'(1);
      else if (do_pop)
        depth <= depth - DW'(1);
      if (en && (op_c == OP_CLR)) begin
        fault      <= 1'b0;
        fault_code <= 2'b00;
      end else if (overflow || underflow) begin
        fault <= 1'b1;
        // First fault since the last clear wins the code.
        if (fault_code == 2'b00)
          fault_code <= overflow ? 2'b01 : 2'b10;
      end
    end
  end

  // Stack contents are not reset; reset_n only gates writes during reset.
  always_ff @(posedge clk) begin
    if (reset_n && do_push)
      stack_mem[push_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_instr_pointer_stack.sv
// Scoreboard bench: two configurations driven in lockstep, checked against a queue-based model.
module tb_instr_pointer_stack;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [2:0]  op;
  logic [15:0] operand;

  logic [15:0] out_a, top_a;
  logic [3:0]  depth_a;
  logic        full_a, empty_a, fault_a;
  logic [1:0]  code_a;

  logic [7:0]  out_b, top_b;
  logic [1:0]  depth_b;
  logic        full_b, empty_b, fault_b;
  logic [1:0]  code_b;

  always #5 clk = ~clk;

  instr_pointer_stack dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .op(op), .operand(operand),
    .out(out_a), .top(top_a), .depth(depth_a), .full(full_a), .empty(empty_a),
    .fault(fault_a), .fault_code(code_a)
  );

  instr_pointer_stack #(
    .WORD_WIDTH(8), .STACK_DEPTH(2), .RESET_ADDR(8'hF0), .STEP(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .op(op), .operand(operand[7:0]),
    .out(out_b), .top(top_b), .depth(depth_b), .full(full_b), .empty(empty_b),
    .fault(fault_b), .fault_code(code_b)
  );

  typedef struct {
    logic [15:0] out;
    logic [15:0] top;
    int unsigned depth;
    logic        full;
    logic        empty;
    logic        fault;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: pointer, fault flags and one LIFO queue per configuration.
  logic [15:0] m_out   [2];
  logic        m_fault [2];
  logic [1:0]  m_code  [2];
  logic [15:0] stk0[$];
  logic [15:0] stk1[$];

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[cfg%0d] t=%0t got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  function automatic int unsigned msize(input int k);
    return (k == 0) ? stk0.size() : stk1.size();
  endfunction

  function automatic logic [15:0] mtop(input int k);
    if (msize(k) == 0) return 16'h0;
    return (k == 0) ? stk0[$] : stk1[$];
  endfunction

  task automatic mpush(input int k, input logic [15:0] v);
    if (k == 0) stk0.push_back(v);
    else        stk1.push_back(v);
  endtask

  task automatic mpop(input int k, output logic [15:0] v);
    if (k == 0) v = stk0.pop_back();
    else        v = stk1.pop_back();
  endtask

  task automatic model_reset();
    m_out[0] = 16'h0000;
    m_out[1] = 16'h00F0;
    stk0.delete();
    stk1.delete();
    for (int k = 0; k < 2; k++) begin
      m_fault[k] = 1'b0;
      m_code[k]  = 2'b00;
    end
  endtask

  task automatic model_step(input int k, input logic e, input logic [2:0] o, input logic [15:0] d);
    logic [15:0] mask;
    logic [15:0] st;
    logic [15:0] cur;
    logic [15:0] v;
    int unsigned cap;
    mask = (k == 0) ? 16'hFFFF : 16'h00FF;
    st   = (k == 0) ? 16'd1 : 16'd2;
    cap  = (k == 0) ? 8 : 2;
    cur  = m_out[k];
    if (!e) return;
    case (o)
      3'd1: m_out[k] = (cur + st) & mask;
      3'd2: m_out[k] = (cur + d) & mask;
      3'd3: m_out[k] = d & mask;
      3'd4, 3'd5: begin
        if (msize(k) == cap) begin
          m_fault[k] = 1'b1;
          if (m_code[k] == 2'b00) m_code[k] = 2'b01;
        end else begin
          mpush(k, (cur + st) & mask);
          m_out[k] = (o == 3'd4) ? ((cur + d) & mask) : (d & mask);
        end
      end
      3'd6: begin
        if (msize(k) == 0) begin
          m_fault[k] = 1'b1;
          if (m_code[k] == 2'b00) m_code[k] = 2'b10;
        end else begin
          mpop(k, v);
          m_out[k] = v;
        end
      end
      3'd7: begin
        m_fault[k] = 1'b0;
        m_code[k]  = 2'b00;
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model_exp(input int k);
    exp_t e;
    int unsigned cap;
    cap     = (k == 0) ? 8 : 2;
    e.out   = m_out[k];
    e.top   = mtop(k);
    e.depth = msize(k);
    e.full  = (msize(k) == cap);
    e.empty = (msize(k) == 0);
    e.fault = m_fault[k];
    e.code  = m_code[k];
    return e;
  endfunction

  task automatic push_expect();
    exp_q0.push_back(model_exp(0));
    exp_q1.push_back(model_exp(1));
  endtask

  task automatic do_op(input logic e, input logic [2:0] o, input logic [15:0] d);
    @(negedge clk);
    en = e; op = o; operand = d;
    model_step(0, e, o, d);
    model_step(1, e, o, d);
    push_expect();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b1; op = 3'($urandom); operand = 16'($urandom);
    reset_n = 1'b0;
    #1;
    check("async_reset_out", 0, 32'(out_a), 32'h0000);
    check("async_reset_out", 1, 32'(out_b), 32'h00F0);
    model_reset();
    push_expect();
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b0;
  endtask

  // Monitor: every cycle after the active edge, pop one expectation per configuration.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check("out",   0, 32'(out_a),   32'(e.out));
        check("top",   0, 32'(top_a),   32'(e.top));
        check("depth", 0, 32'(depth_a), 32'(e.depth));
        check("full",  0, 32'(full_a),  32'(e.full));
        check("empty", 0, 32'(empty_a), 32'(e.empty));
        check("fault", 0, 32'(fault_a), 32'(e.fault));
        check("code",  0, 32'(code_a),  32'(e.code));
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check("out",   1, 32'(out_b),   32'(e.out[7:0]));
        check("top",   1, 32'(top_b),   32'(e.top[7:0]));
        check("depth", 1, 32'(depth_b), 32'(e.depth));
        check("full",  1, 32'(full_b),  32'(e.full));
        check("empty", 1, 32'(empty_b), 32'(e.empty));
        check("fault", 1, 32'(fault_b), 32'(e.fault));
        check("code",  1, 32'(code_b),  32'(e.code));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; op = 3'd0; operand = 16'h0;
    model_reset();
    do_reset();

    // Basic stepping, then an asynchronous reset mid-run.
    repeat (3) do_op(1'b1, 3'd1, 16'h0);
    settle();
    check("step3_out", 0, 32'(out_a), 32'h0003);
    do_reset();

    // Relative and absolute jumps with wrap-around.
    do_op(1'b1, 3'd3, 16'h0010);
    do_op(1'b1, 3'd2, 16'hFFFE);
    settle();
    check("rel_neg_out", 0, 32'(out_a), 32'h000E);
    do_op(1'b1, 3'd3, 16'hFFFF);
    do_op(1'b1, 3'd1, 16'h0);
    settle();
    check("wrap_out", 0, 32'(out_a), 32'h0000);
    check("wrap_fault", 0, 32'(fault_a), 32'h0);

    // Nested call and return.
    do_op(1'b1, 3'd3, 16'h0100);
    do_op(1'b1, 3'd5, 16'h0200);
    settle();
    check("call_abs_top", 0, 32'(top_a), 32'h0101);
    do_op(1'b1, 3'd4, 16'h0010);
    settle();
    check("call_rel_out", 0, 32'(out_a), 32'h0210);
    check("call_rel_top", 0, 32'(top_a), 32'h0201);
    do_op(1'b1, 3'd6, 16'h0);
    do_op(1'b1, 3'd6, 16'h0);
    settle();
    check("ret2_out", 0, 32'(out_a), 32'h0101);
    check("ret2_empty", 0, 32'(empty_a), 32'h1);

    // Overflow on the ninth call; state is preserved.
    for (int unsigned i = 0; i < 8; i++) do_op(1'b1, 3'd5, 16'(16'h1000 + i));
    do_op(1'b1, 3'd5, 16'h2000);
    settle();
    check("ovf_out", 0, 32'(out_a), 32'h1007);
    check("ovf_depth", 0, 32'(depth_a), 32'd8);
    check("ovf_code", 0, 32'(code_a), 32'h1);
    do_op(1'b1, 3'd6, 16'h0);
    settle();
    check("ovf_ret_out", 0, 32'(out_a), 32'h1007);

    // Drain, clear, underflow, then overflow keeps the underflow code.
    repeat (7) do_op(1'b1, 3'd6, 16'h0);
    do_op(1'b1, 3'd7, 16'h0);
    do_op(1'b1, 3'd6, 16'h0);
    settle();
    check("udf_code", 0, 32'(code_a), 32'h2);
    for (int unsigned i = 0; i < 9; i++) do_op(1'b1, 3'd4, 16'(i * 3));
    settle();
    check("sticky_code", 0, 32'(code_a), 32'h2);
    check("sticky_code", 1, 32'(code_b), 32'h2);
    do_op(1'b1, 3'd7, 16'h0);
    settle();
    check("clr_fault", 0, 32'(fault_a), 32'h0);
    check("clr_code", 1, 32'(code_b), 32'h0);

    // Disabled cycles must not change state.
    repeat (5) do_op(1'b0, 3'd1, 16'($urandom));

    // Second configuration: return offset of 2 from the reset address.
    do_reset();
    do_op(1'b1, 3'd5, 16'h0010);
    settle();
    check("cfg_call_top", 1, 32'(top_b), 32'h00F2);
    check("cfg_call_out", 1, 32'(out_b), 32'h0010);

    // Randomized traffic.
    for (int unsigned i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      do_op(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), 16'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 0, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_pointer_stack.md
Name: instr_pointer_stack

Overview:
Parameterised instruction pointer that adds call/return support to the program counter. It offers relative, absolute, call and return updates with an internal return-address stack of configurable depth. It sits in the fetch stage and drives the fetch address; the decoder supplies op and operand each cycle. Stack overflow and underflow are detected, raise a sticky fault and never corrupt state.

Parameters:
WORD_WIDTH, 16, width of the address, operand and stack entries
STACK_DEPTH, 8, number of return-address entries (>=1)
RESET_ADDR, 0, value loaded into out on reset
STEP, 1, increment used by STEP and as the call return offset

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset_n  input  1  asynchronous, active-low reset
en  input  1  op is executed on a rising clk edge only when en=1
op  input  3  0 HOLD, 1 STEP, 2 REL, 3 ABS, 4 CALL_REL, 5 CALL_ABS, 6 RET, 7 CLR_FAULT
operand  input  WORD_WIDTH  signed offset (REL, CALL_REL) or target address (ABS, CALL_ABS)
out  output  WORD_WIDTH  current instruction pointer, registered
top  output  WORD_WIDTH  stack top entry; 0 when the stack is empty; combinational from registers
depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
full  output  1  depth==STACK_DEPTH
empty  output  1  depth==0
fault  output  1  sticky; set by overflow or underflow
fault_code  output  2  00 none, 01 overflow, 10 underflow; holds the first fault since it was last cleared

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately): out=RESET_ADDR, depth=0, fault=0, fault_code=00. Stack contents are don't-care.
- Reset asserted mid-operation overrides any op in flight. First op is taken on the first rising edge after reset_n goes high.
- en=0, or en=1 with HOLD: no state change.
- Latency: one cycle. The new out, depth and fault values are visible after the executing edge.
- STEP: out <= out+STEP.
- REL: out <= out+operand, two's complement.
- ABS: out <= operand.
- CALL_REL: push out+STEP, then out <= out+operand.
- CALL_ABS: push out+STEP, then out <= operand.
- RET: out <= top, pop.
- CLR_FAULT: fault=0, fault_code=00. out is unchanged.
- Arithmetic: all additions are modulo 2^WORD_WIDTH. Wrap-around is silent and not a fault. Pushed return addresses wrap the same way.
- Overflow (CALL_* while full=1):
  - no push, out unchanged, depth unchanged;
  - fault=1;
  - fault_code=01 if it was 00.
- Underflow (RET while empty=1):
  - out unchanged, depth unchanged;
  - fault=1;
  - fault_code=10 if it was 00.
- Fault behaviour:
  - a fault does not block later ops; non-faulting ops keep executing normally;
  - fault stays set until CLR_FAULT or reset;
  - a new fault while fault=1 keeps the original fault_code.
- Stack is LIFO. top reflects entry depth-1.
- A push followed by a pop returns exactly the pushed value.
- Entries above depth retain stale data, which must never appear on top.
- Undefined op encodings do not exist: all 8 are defined.
- Implementation: register-array stack with a pointer. No combinational path from inputs to out.

Test Plan:
1. Reset, then STEP x3 (defaults) -> out=0,1,2,3; depth=0; fault=0. Assert reset_n low mid-run -> out=0 immediately, without waiting for a clock edge.
2. out=0x0010:
   - REL operand=0xFFFE -> out=0x000E;
   - ABS 0xFFFF, then STEP -> out=0x0000 (wrap), fault=0.
3. out=0x0100:
   - CALL_ABS 0x0200 -> out=0x0200, top=0x0101, depth=1;
   - CALL_REL 0x0010 -> out=0x0210, top=0x0201, depth=2;
   - RET -> out=0x0201, depth=1;
   - RET -> out=0x0101, depth=0, empty=1.
4. Nine CALL_ABS with STACK_DEPTH=8 -> the 9th leaves out unchanged, depth=8, full=1, fault=1, fault_code=01. RET then returns the 8th pushed value.
5. RET on an empty stack -> out unchanged, fault_code=10. A subsequent overflow keeps fault_code=10. CLR_FAULT -> fault=0, fault_code=00.
6. en=0 with op=STEP for 5 cycles -> out constant. Repeat test 3 with WORD_WIDTH=8, STACK_DEPTH=2, RESET_ADDR=0xF0, STEP=2 -> reset out=0xF0; CALL_ABS 0x10 pushes 0xF2.
